// File: rtl/speed_report_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : speed_report_uart_tx_pkg
// Description : Constants, state encodings and helpers for the speed-report
//               UART transmitter: frame header and length, controller and
//               byte-serializer state encodings, and baud-period calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package speed_report_uart_tx_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         FRAME_LEN = 5;

    // Record controller states
    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_LOAD = 2'd1,
        CTRL_SEND = 2'd2
    } ctrl_state_t;

    // Byte serializer states; BYTE_IDLE is the line-high rest state
    typedef enum logic [1:0] {
        BYTE_IDLE  = 2'd0,
        BYTE_START = 2'd1,
        BYTE_DATA  = 2'd2,
        BYTE_STOP  = 2'd3
    } byte_state_t;

    // Clock cycles per UART bit (integer division, truncating)
    function automatic int bit_cyc(input int sys_freq, input int baud);
        return sys_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/speed_report_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : speed_report_uart_tx_if
// Description : Record handshake between the measurement core (master) and
//               the speed-report UART transmitter (slave).
//   rec_valid  master->slave  record offered this cycle
//   rec_speed  master->slave  speed value, WIDTH_SPEED bits
//   rec_epass  master->slave  2-bit Epass status code
//   rec_ready  slave->master  pending buffer empty; accept = valid & ready
// Revision    : 1.0 - initial release
// ============================================================================
interface speed_report_uart_tx_if #(
    parameter int WIDTH_SPEED = 14
);
    logic                   rec_valid;
    logic [WIDTH_SPEED-1:0] rec_speed;
    logic [1:0]             rec_epass;
    logic                   rec_ready;

    modport master (
        output rec_valid,
        output rec_speed,
        output rec_epass,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_speed,
        input  rec_epass,
        output rec_ready
    );
endinterface
`default_nettype wire

// File: rtl/speed_report_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serializer, LSB first, each bit held BIT_CYC cycles.
//   clk      in   system clock
//   rst      in   synchronous active-high reset (line returns high)
//   i_start  in   load i_data and begin a start bit; honoured when idle or
//                 in the final stop-bit cycle (back-to-back bytes)
//   i_data   in   byte to send
//   o_tx     out  registered serial line, idle high
//   o_done   out  1-cycle pulse during the last cycle of the stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import speed_report_uart_tx_pkg::*;
#(
    parameter int BIT_CYC = 5208
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_start,
    input  wire logic [7:0] i_data,
    output logic            o_tx,
    output logic            o_done
);

    localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BIT_CYC - 1);

    byte_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;

    logic w_bit_end;
    logic w_load;

    assign w_bit_end = (r_state != BYTE_IDLE) && (r_cnt == c_cnt_last);
    assign o_done    = (r_state == BYTE_STOP) && w_bit_end;
    // Accepting a start in the final stop cycle removes any gap between bytes
    assign w_load    = i_start && ((r_state == BYTE_IDLE) || o_done);
    assign o_tx      = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= BYTE_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else if (w_load) begin
            r_state   <= BYTE_START;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= i_data;
            r_tx      <= 1'b0;
        end else if (r_state != BYTE_IDLE) begin
            if (!w_bit_end) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
                case (r_state)
                    BYTE_START: begin
                        r_state <= BYTE_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end
                    BYTE_DATA: begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= BYTE_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end
                    BYTE_STOP: begin
                        r_state <= BYTE_IDLE;
                        r_tx    <= 1'b1;
                    end
                    default: begin
                        r_state <= BYTE_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/speed_report_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : speed_report_uart_tx
// Description : Frames each vehicle record into 5 bytes
//               {A5, speed[15:8], speed[7:0], epass, xor-checksum} and sends
//               them as UART 8N1. One pending record is buffered while a
//               frame is on the line; extra records are dropped and flagged.
//   clk              in   system clock
//   reset            in   synchronous active-high reset
//   rec_if           slave record handshake (valid/speed/epass/ready)
//   serial_data_out  out  UART line, idle high
//   busy             out  high from first start bit to last stop bit
//   overrun          out  high in any cycle a record is offered while full
// Revision    : 1.0 - initial release
// ============================================================================
module speed_report_uart_tx
    import speed_report_uart_tx_pkg::*;
#(
    parameter int SYS_FREQ    = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int WIDTH_SPEED = 14
) (
    input  wire logic             clk,
    input  wire logic             reset,
    speed_report_uart_tx_if.slave rec_if,
    output logic                  serial_data_out,
    output logic                  busy,
    output logic                  overrun
);

    localparam int BIT_CYC = bit_cyc(SYS_FREQ, BAUD);

    if ((WIDTH_SPEED < 1) || (WIDTH_SPEED > 16)) begin : g_width_check
        $error("speed_report_uart_tx: WIDTH_SPEED must be within 1..16");
    end

    if (BIT_CYC < 1) begin : g_baud_check
        $error("speed_report_uart_tx: SYS_FREQ/BAUD must be at least 1");
    end

    // Pending record buffer
    logic                   r_buf_full;
    logic [WIDTH_SPEED-1:0] r_buf_speed;
    logic [1:0]             r_buf_epass;

    // Record currently on the line
    logic [WIDTH_SPEED-1:0] r_frm_speed;
    logic [1:0]             r_frm_epass;

    ctrl_state_t r_state;
    logic [2:0]  r_byte_idx;
    logic        r_busy;

    logic        w_accept;
    logic        w_load;
    logic        w_byte_done;
    logic        w_last_byte;
    logic        w_byte_start;
    logic [15:0] w_speed16;
    logic [7:0]  w_b1;
    logic [7:0]  w_b2;
    logic [7:0]  w_b3;
    logic [7:0]  w_chk;
    logic [7:0]  w_byte_data;

    assign w_accept         = rec_if.rec_valid & ~r_buf_full;
    assign rec_if.rec_ready = ~r_buf_full;
    assign overrun          = rec_if.rec_valid & r_buf_full;
    assign busy             = r_busy;

    assign w_load      = (r_state == CTRL_LOAD);
    assign w_last_byte = (r_byte_idx == 3'(FRAME_LEN - 1));
    // Header goes out straight from LOAD; later bytes chain off the
    // serializer's done pulse so bytes run back-to-back.
    assign w_byte_start = w_load |
                          ((r_state == CTRL_SEND) & w_byte_done & ~w_last_byte);

    assign w_speed16 = 16'(r_frm_speed);
    assign w_b1      = w_speed16[15:8];
    assign w_b2      = w_speed16[7:0];
    assign w_b3      = {6'b0, r_frm_epass};
    assign w_chk     = w_b1 ^ w_b2 ^ w_b3;

    // Byte to load next: header during LOAD, otherwise the byte after r_byte_idx
    always_comb begin
        w_byte_data = FRAME_HDR;
        if (!w_load) begin
            case (r_byte_idx)
                3'd0:    w_byte_data = w_b1;
                3'd1:    w_byte_data = w_b2;
                3'd2:    w_byte_data = w_b3;
                3'd3:    w_byte_data = w_chk;
                default: w_byte_data = FRAME_HDR;
            endcase
        end
    end

    // A new accept in the same cycle as LOAD wins the buffer; LOAD has
    // already taken the old entry into the frame register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_full  <= 1'b0;
            r_buf_speed <= '0;
            r_buf_epass <= 2'd0;
        end else if (w_accept) begin
            r_buf_full  <= 1'b1;
            r_buf_speed <= rec_if.rec_speed;
            r_buf_epass <= rec_if.rec_epass;
        end else if (w_load) begin
            r_buf_full  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CTRL_IDLE;
            r_byte_idx  <= 3'd0;
            r_busy      <= 1'b0;
            r_frm_speed <= '0;
            r_frm_epass <= 2'd0;
        end else begin
            case (r_state)
                CTRL_IDLE: begin
                    if (r_buf_full | w_accept) begin
                        r_state <= CTRL_LOAD;
                    end
                end
                CTRL_LOAD: begin
                    r_frm_speed <= r_buf_speed;
                    r_frm_epass <= r_buf_epass;
                    r_byte_idx  <= 3'd0;
                    r_busy      <= 1'b1;
                    r_state     <= CTRL_SEND;
                end
                CTRL_SEND: begin
                    if (w_byte_done) begin
                        if (w_last_byte) begin
                            r_busy  <= 1'b0;
                            // Pending record goes straight to LOAD: one idle cycle
                            r_state <= (r_buf_full | w_accept) ? CTRL_LOAD : CTRL_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= CTRL_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .BIT_CYC (BIT_CYC)
    ) u_byte (
        .clk     (clk),
        .rst     (reset),
        .i_start (w_byte_start),
        .i_data  (w_byte_data),
        .o_tx    (serial_data_out),
        .o_done  (w_byte_done)
    );

endmodule
`default_nettype wire
